// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice scheduler with oldest-voice stealing
// One event in flight: latch in IDLE, scan one voice per cycle, apply the update in COMMIT.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      panic,
    input  logic                      event_valid,
    output logic                      event_ready,
    input  logic                      event_on,
    input  logic [6:0]                event_note,
    input  logic [6:0]                event_vel,
    output logic [16*NUM_VOICES-1:0]  voice_note_vol,
    output logic [NUM_VOICES-1:0]     voice_active,
    output logic                      stolen
);
    localparam int K_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                r_state;
    logic [K_W-1:0]        r_k;
    logic                  r_on;
    logic [6:0]            r_hnote;
    logic [6:0]            r_hvel;
    logic                  r_match_found;
    logic [K_W-1:0]        r_match_idx;
    logic                  r_free_found;
    logic [K_W-1:0]        r_free_idx;
    logic                  r_old_found;
    logic [K_W-1:0]        r_old_idx;
    logic [AGE_W-1:0]      r_old_age;
    logic                  r_stolen;

    logic [NUM_VOICES-1:0] r_active;
    logic [6:0]            r_note [NUM_VOICES];
    logic [7:0]            r_vol  [NUM_VOICES];
    logic [AGE_W-1:0]      r_age  [NUM_VOICES];

    logic [K_W-1:0]        w_tgt;
    logic                  w_use_old;

    // Note-on target priority: retrigger a matching voice, else a free one, else steal the oldest.
    always_comb begin
        w_tgt     = r_old_idx;
        w_use_old = 1'b0;
        if (r_match_found) begin
            w_tgt = r_match_idx;
        end else if (r_free_found) begin
            w_tgt = r_free_idx;
        end else begin
            w_use_old = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_k           <= '0;
            r_on          <= 1'b0;
            r_hnote       <= '0;
            r_hvel        <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
            r_stolen      <= 1'b0;
            r_active      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
                r_vol[i]  <= '0;
                r_age[i]  <= '0;
            end
        end else if (panic) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_stolen <= 1'b0;
            r_active <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            r_stolen <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (event_valid) begin
                        r_on          <= event_on && (event_vel != 7'd0);
                        r_hnote       <= event_note;
                        r_hvel        <= event_vel;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                        r_old_found   <= 1'b0;
                        r_old_age     <= '0;
                        r_k           <= '0;
                        r_state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_active[r_k]) begin
                        if (!r_match_found && r_note[r_k] == r_hnote) begin
                            r_match_found <= 1'b1;
                            r_match_idx   <= r_k;
                        end
                        // Strict compare keeps the lowest index on equal ages.
                        if (!r_old_found || r_age[r_k] > r_old_age) begin
                            r_old_found <= 1'b1;
                            r_old_idx   <= r_k;
                            r_old_age   <= r_age[r_k];
                        end
                    end else if (!r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_k;
                    end
                    if (r_k == K_W'(NUM_VOICES - 1)) begin
                        r_k     <= '0;
                        r_state <= COMMIT;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                COMMIT: begin
                    if (r_on) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (K_W'(i) == w_tgt) begin
                                r_active[i] <= 1'b1;
                                r_note[i]   <= r_hnote;
                                r_vol[i]    <= {r_hvel, r_hvel[6]};
                                r_age[i]    <= '0;
                            end else if (r_active[i] && r_age[i] != '1) begin
                                r_age[i] <= r_age[i] + 1'b1;
                            end
                        end
                        r_stolen <= w_use_old;
                    end else if (r_match_found) begin
                        r_active[r_match_idx] <= 1'b0;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        voice_note_vol = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note_vol[16*i +: 16] = {1'b0, r_note[i], r_active[i] ? r_vol[i] : 8'h00};
        end
    end

    assign voice_active = r_active;
    assign stolen       = r_stolen;
    assign event_ready  = (r_state == IDLE);

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - self-checking bench for voice_allocator
module tb_voice_allocator;
    localparam int N    = 4;
    localparam int AW   = 4;
    localparam int AMAX = (1 << AW) - 1;

    logic          clk;
    logic          reset;
    logic          panic;
    logic          event_valid;
    logic          event_ready;
    logic          event_on;
    logic [6:0]    event_note;
    logic [6:0]    event_vel;
    logic [16*N-1:0] voice_note_vol;
    logic [N-1:0]  voice_active;
    logic          stolen;

    voice_allocator #(.NUM_VOICES(N), .AGE_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .panic          (panic),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_on       (event_on),
        .event_note     (event_note),
        .event_vel      (event_vel),
        .voice_note_vol (voice_note_vol),
        .voice_active   (voice_active),
        .stolen         (stolen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int m_act  [N];
    int m_note [N];
    int m_vol  [N];
    int m_age  [N];

    logic [16*N-1:0] g_vnv;
    logic [N-1:0]    g_act;
    logic            g_st;

    typedef struct {
        bit         on;
        int         note;
        int         vel;
        int         idx;
        logic [15:0] word;
        logic [3:0] act;
        bit         st;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_note[i] = 0; m_vol[i] = 0; m_age[i] = 0;
        end
    endfunction

    function automatic void model_panic();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_age[i] = 0;
        end
    endfunction

    // Returns 1 when the note-on had to steal a sounding voice.
    function automatic bit model_event(input bit on, input int note, input int vel);
        int t;
        int best;
        bit st;
        t  = -1;
        st = 0;
        for (int i = 0; i < N; i++)
            if (t < 0 && m_act[i] != 0 && m_note[i] == note) t = i;
        if (!on || vel == 0) begin
            if (t >= 0) m_act[t] = 0;
            return 0;
        end
        for (int i = 0; i < N; i++)
            if (t < 0 && m_act[i] == 0) t = i;
        if (t < 0) begin
            best = 0;
            for (int i = 1; i < N; i++)
                if (m_age[i] > m_age[best]) best = i;
            t  = best;
            st = 1;
        end
        for (int i = 0; i < N; i++)
            if (i != t && m_act[i] != 0 && m_age[i] < AMAX) m_age[i]++;
        m_act[t]  = 1;
        m_note[t] = note;
        m_vol[t]  = vel * 2 + vel / 64;
        m_age[t]  = 0;
        return st;
    endfunction

    task automatic compare_all(input string tag);
        logic [N-1:0] ea;
        int ew;
        for (int i = 0; i < N; i++) begin
            ew = m_note[i] * 256 + ((m_act[i] != 0) ? m_vol[i] : 0);
            check($sformatf("%s word v%0d", tag, i), voice_note_vol[16*i +: 16], ew);
            ea[i] = (m_act[i] != 0);
        end
        check({tag, " active"}, voice_active, ea);
    endtask

    task automatic send(input bit on, input int note, input int vel, input string tag);
        int w;
        bit exp_st;
        logic [16*N-1:0] pre_vnv;
        w = 0;
        while (event_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready before send"}, event_ready, 1'b1);
        pre_vnv     = voice_note_vol;
        event_on    = on;
        event_note  = note[6:0];
        event_vel   = vel[6:0];
        event_valid = 1'b1;
        @(posedge clk);
        #1 event_valid = 1'b0;
        exp_st = model_event(on, note, vel);
        repeat (N) @(posedge clk);
        @(negedge clk);
        check({tag, " busy in commit"}, event_ready, 1'b0);
        check({tag, " outputs held"}, voice_note_vol, pre_vnv);
        check({tag, " no early stolen"}, stolen, 1'b0);
        @(negedge clk);
        g_vnv = voice_note_vol;
        g_act = voice_active;
        g_st  = stolen;
        check({tag, " stolen"}, stolen, exp_st);
        check({tag, " ready after"}, event_ready, 1'b1);
        compare_all(tag);
        @(negedge clk);
        check({tag, " stolen one cycle"}, stolen, 1'b0);
    endtask

    task automatic do_panic();
        @(negedge clk);
        panic = 1'b1;
        @(posedge clk);
        #1 panic = 1'b0;
        model_panic();
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int last;
        int nts[4];
        bit on;
        int note;
        int vel;
        logic [16*N-1:0] snap;

        reset = 1'b0; panic = 1'b0; event_valid = 1'b0;
        event_on = 1'b0; event_note = '0; event_vel = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset words", voice_note_vol, '0);
        check("reset active", voice_active, '0);
        check("reset stolen", stolen, 1'b0);
        check("reset ready", event_ready, 1'b1);
        reset = 1'b1;
        @(negedge clk);

        tbl[0] = '{1'b1, 60, 100, 0, 16'h3CC9, 4'b0001, 1'b0};
        tbl[1] = '{1'b1, 62, 127, 1, 16'h3EFF, 4'b0011, 1'b0};
        tbl[2] = '{1'b1, 64,   1, 2, 16'h4002, 4'b0111, 1'b0};
        tbl[3] = '{1'b1, 65,  64, 3, 16'h4181, 4'b1111, 1'b0};
        tbl[4] = '{1'b1, 67,  10, 0, 16'h4314, 4'b1111, 1'b1};
        tbl[5] = '{1'b0, 62,  33, 1, 16'h3E00, 4'b1101, 1'b0};
        tbl[6] = '{1'b1, 70, 100, 1, 16'h46C9, 4'b1111, 1'b0};
        tbl[7] = '{1'b1, 64,  50, 2, 16'h4064, 4'b1111, 1'b0};
        tbl[8] = '{1'b1, 60,   0, 0, 16'h4314, 4'b1111, 1'b0};
        tbl[9] = '{1'b1, 72, 127, 3, 16'h48FF, 4'b1111, 1'b1};
        for (int t = 0; t < 10; t++) begin
            send(tbl[t].on, tbl[t].note, tbl[t].vel, $sformatf("tbl%0d", t));
            check($sformatf("tbl%0d vec word", t), g_vnv[16*tbl[t].idx +: 16], tbl[t].word);
            check($sformatf("tbl%0d vec active", t), g_act, tbl[t].act);
            check($sformatf("tbl%0d vec stolen", t), g_st, tbl[t].st);
        end

        do_panic();
        compare_all("after panic");
        send(1'b1, 60, 100, "retrig a");
        check("retrig a word", g_vnv[15:0], 16'h3CC9);
        send(1'b1, 60, 50, "retrig b");
        check("retrig b word", g_vnv[15:0], 16'h3C64);
        check("retrig b active", g_act, 4'b0001);
        send(1'b1, 60, 0, "vel0 off");
        check("vel0 off word", g_vnv[15:0], 16'h3C00);
        check("vel0 off active", g_act, 4'b0000);
        snap = voice_note_vol;
        send(1'b0, 70, 0, "off unheld");
        check("off unheld unchanged", g_vnv, snap);

        send(1'b1, 40, 20, "scanpanic a");
        send(1'b1, 41, 20, "scanpanic b");
        event_on = 1'b1; event_note = 7'd50; event_vel = 7'd90; event_valid = 1'b1;
        @(posedge clk);
        #1 event_valid = 1'b0;
        @(posedge clk);
        #1 panic = 1'b1;
        @(posedge clk);
        #1 panic = 1'b0;
        model_panic();
        @(negedge clk);
        check("scan panic active", voice_active, '0);
        check("scan panic ready", event_ready, 1'b1);
        repeat (N + 2) @(negedge clk);
        compare_all("scan panic settle");

        nts[0] = 48; nts[1] = 52; nts[2] = 55; nts[3] = 59;
        acc = 0; last = -1;
        event_on = 1'b1; event_note = 7'd48; event_vel = 7'd77; event_valid = 1'b1;
        for (int c = 0; c < 60 && acc < 4; c++) begin
            @(negedge clk);
            if (event_ready) begin
                if (last >= 0) check("b2b interval", c - last, N + 2);
                last = c;
                @(posedge clk);
                #1;
                void'(model_event(1'b1, nts[acc], 77));
                acc++;
                if (acc < 4) event_note = nts[acc][6:0];
                else event_valid = 1'b0;
            end
        end
        event_valid = 1'b0;
        check("b2b accepted", acc, 4);
        repeat (N + 2) @(negedge clk);
        compare_all("b2b final");

        for (int r = 0; r < 80; r++) begin
            on   = ($urandom_range(0, 3) != 0);
            note = 60 + $urandom_range(0, 7);
            vel  = $urandom_range(0, 127);
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk);
                panic = 1'b1; event_valid = 1'b1;
                event_on = on; event_note = note[6:0]; event_vel = vel[6:0];
                @(posedge clk);
                #1 panic = 1'b0; event_valid = 1'b0;
                model_panic();
                @(negedge clk);
                check("panic blocks accept", event_ready, 1'b1);
                compare_all("rand panic");
            end else begin
                send(on, note, vel, $sformatf("rand%0d", r));
            end
        end

        @(negedge clk);
        event_on = 1'b1; event_note = 7'd55; event_vel = 7'd60; event_valid = 1'b1;
        @(posedge clk);
        #1 event_valid = 1'b0;
        repeat (N) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midcommit reset words", voice_note_vol, '0);
        check("midcommit reset active", voice_active, '0);
        check("midcommit reset stolen", stolen, 1'b0);
        check("midcommit reset ready", event_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        send(1'b1, 61, 5, "post reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler for the MIDI synthesizer. It accepts decoded note-on/note-off events through a valid/ready handshake and assigns each note to one of NUM_VOICES waveform-generator voices. For every voice it drives the 16-bit note/volume word the generator consumes: bit 15 = 0, [14:8] = MIDI note, [7:0] = volume. It sits between the MIDI event decoder and the bank of waveform generators. When every voice is busy, it steals the oldest one.

## Interface

Parameters:
- NUM_VOICES, default 4: number of voices; legal range 2..16.
- AGE_W, default 4: width of the per-voice age counter, which saturates.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-low. Asserted when 0.
- panic, input, 1: all-notes-off pulse. Takes priority over everything except reset.
- event_valid, input, 1: an event is presented.
- event_ready, output, 1: the block can accept an event.
- event_on, input, 1: 1 = note-on, 0 = note-off.
- event_note, input, 7: MIDI note number.
- event_vel, input, 7: MIDI velocity.
- voice_note_vol, output, 16*NUM_VOICES: packed per-voice words. Voice i occupies [16i+15:16i].
- voice_active, output, NUM_VOICES: 1 = the voice is sounding.
- stolen, output, 1: one-cycle pulse when a note-on has stolen a busy voice.

## Operation

- Per-voice registers: active (1 b), note (7 b), vol (8 b), age (AGE_W b).
  - voice_note_vol[i] = {1'b0, note, active ? vol : 8'h00}.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - event_ready = 1.
  - On event_valid && event_ready, latch on/note/vel into holding registers and go to SCAN.
  - A note-on with vel = 0 is latched as a note-off.
- SCAN: visits voice index k = 0..NUM_VOICES-1, one voice per cycle. Tracks three results:
  - match: the first active voice with note == held note;
  - free: the first inactive voice;
  - oldest: the active voice with maximum age, ties going to the lowest index.
  - After k = NUM_VOICES-1, go to COMMIT.
- COMMIT, note-on, target selected in priority order match > free > oldest:
  - Target gets active = 1, note = held note, vol = {vel, vel[6]} (so 127 maps to 255, 1 maps to 2), age = 0.
  - Every other active voice increments its age, saturating at 2^AGE_W-1.
  - stolen = 1 for this cycle only when the oldest path was used.
- COMMIT, note-off:
  - If a match exists, that voice gets active = 0; note and age are retained.
  - If there is no match, no state changes.
  - Ages of other voices are unchanged on note-off.
- After COMMIT, return to IDLE.
- panic = 1, in any state:
  - All active and age bits clear; notes are retained.
  - FSM returns to IDLE; any held event is discarded.
  - If panic and event_valid are both high in IDLE, the event is not accepted.
- Voices are independent; only one event is in flight at a time.

## Timing

- Reset (reset = 0) values:
  - voice_note_vol = all 0, voice_active = 0, stolen = 0.
  - Ages 0, FSM in IDLE, scan index 0.
  - event_ready = 1 because the state is IDLE.
- Latency:
  - Accept edge at T.
  - SCAN spans T+1 .. T+NUM_VOICES.
  - The COMMIT cycle is T+NUM_VOICES+1.
  - Updated outputs and the stolen pulse are visible after the edge ending COMMIT, at T+NUM_VOICES+2. event_ready is 1 again in that same cycle.
- Throughput: one event per NUM_VOICES+2 cycles.
- event_ready is decoded from the FSM state only, never from event_valid.
- The upstream block must hold its event fields stable while event_valid = 1 && event_ready = 0.
- Asynchronous reset mid-SCAN or mid-COMMIT aborts the event; no partial voice update is allowed.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Reset then note-on (60, vel 100), NUM_VOICES = 4 -> at T+6: voice 0 word = 16'h3CC9 (note 60, vol 0xC9), voice_active = 4'b0001, stolen = 0.
- Note-ons 60, 62, 64, 65, then note-on 67 -> voice 0 (the oldest, age 3) is stolen and its word becomes {0, 67, vol}. stolen pulses for one cycle and voice_active = 4'b1111.
- Note-on 60 vel 100, then note-on 60 vel 50 -> voice 0 is retriggered with vol 0x64 and no other voice is allocated. Then note-on 60 vel 0 -> voice 0 inactive, word = 16'h3C00.
- Note-off 70 with no voice holding note 70 -> no output change. event_ready returns after 6 cycles.
- Hold event_valid = 1 continuously with four different notes -> exactly one acceptance per 6 cycles and no event dropped or duplicated.
- panic asserted during SCAN of a note-on with two voices active -> voice_active = 0 on the next cycle, the in-flight note is never allocated, and event_ready = 1 the following cycle. Also assert reset = 0 mid-COMMIT -> all outputs read 0 immediately.
